// File: rtl/delay_detect8.sv
// delay_detect8
//   Measures the 0..3-cycle register delay between a reference byte stream
//   and a delayed copy of it. The result is a 2-bit tap select that can drive
//   the sel input of the matching delay line. Lock and loss of lock are
//   tracked.
//
//   Ports:
//     clk       in   single clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     en        in   compare enable; low freezes SEARCH/LOCKED progress
//     ref_d     in   [WIDTH-1:0] undelayed reference data
//     dly_d     in   [WIDTH-1:0] delayed data under test
//     sel       out  [1:0] detected delay, valid while locked
//     locked    out  high while in LOCKED
//     lock_lost out  one-cycle pulse on LOCKED -> SEARCH
//     busy      out  high in FILL and SEARCH
module delay_detect8 #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 8,
    parameter int ERR_MAX  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] ref_d,
    input  logic [WIDTH-1:0] dly_d,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             lock_lost,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_CNT_C = LOCK_CNT[7:0];
    localparam logic [7:0] ERR_MAX_C  = ERR_MAX[7:0];

    // Index of the lowest set bit; the smallest delay wins ties.
    function automatic logic [1:0] lowest_tap(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0]) begin
            idx = 2'd0;
        end else if (m[1]) begin
            idx = 2'd1;
        end else if (m[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] hist1_r, hist2_r, hist3_r;
    logic [1:0]       fill_r, fill_s;
    logic [3:0]       mask_r, mask_s;
    logic [7:0]       good_r, good_s;
    logic [7:0]       err_r, err_s;
    logic [1:0]       sel_r, sel_s;
    logic             locked_r, locked_s;
    logic             lost_r, lost_s;
    logic             busy_r;

    logic [3:0]       match_s;
    logic [3:0]       next_mask_s;
    logic [7:0]       good_inc_s;
    logic [7:0]       err_inc_s;

    assign match_s[0]  = (dly_d == ref_d);
    assign match_s[1]  = (dly_d == hist1_r);
    assign match_s[2]  = (dly_d == hist2_r);
    assign match_s[3]  = (dly_d == hist3_r);
    assign next_mask_s = mask_r & match_s;
    assign good_inc_s  = sat_inc(good_r);
    assign err_inc_s   = sat_inc(err_r);

    // Reference history shift register; runs every clock regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_r <= '0;
            hist2_r <= '0;
            hist3_r <= '0;
        end else begin
            hist1_r <= ref_d;
            hist2_r <= hist1_r;
            hist3_r <= hist2_r;
        end
    end

    // Next-state and next-output decode for the FILL/SEARCH/LOCKED machine.
    always_comb begin
        state_s  = state_r;
        fill_s   = fill_r;
        mask_s   = mask_r;
        good_s   = good_r;
        err_s    = err_r;
        sel_s    = sel_r;
        locked_s = locked_r;
        lost_s   = 1'b0;
        case (state_r)
            ST_FILL: begin
                // Leave FILL on the edge that brings the counter to 3, so
                // all three history registers hold real data.
                fill_s = fill_r + 2'd1;
                if (fill_r == 2'd2) begin
                    state_s = ST_SEARCH;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_SEARCH: begin
                if (en) begin
                    if (next_mask_s != 4'b0000) begin
                        mask_s = next_mask_s;
                        good_s = good_inc_s;
                        if (good_inc_s == LOCK_CNT_C) begin
                            sel_s    = lowest_tap(next_mask_s);
                            state_s  = ST_LOCKED;
                            locked_s = 1'b1;
                            err_s    = 8'd0;
                        end else begin
                            state_s = ST_SEARCH;
                        end
                    end else begin
                        // No tap survived: restart the qualification window.
                        mask_s = 4'b1111;
                        good_s = 8'd0;
                    end
                end else begin
                    state_s = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (en) begin
                    if (match_s[sel_r]) begin
                        err_s = 8'd0;
                    end else begin
                        err_s = err_inc_s;
                        if (err_inc_s == ERR_MAX_C) begin
                            state_s  = ST_SEARCH;
                            locked_s = 1'b0;
                            lost_s   = 1'b1;
                            mask_s   = 4'b1111;
                            good_s   = 8'd0;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s  = ST_FILL;
                fill_s   = 2'd0;
                mask_s   = 4'b1111;
                good_s   = 8'd0;
                err_s    = 8'd0;
                locked_s = 1'b0;
            end
        endcase
    end

    // State and output registers; busy is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_FILL;
            fill_r   <= 2'd0;
            mask_r   <= 4'b1111;
            good_r   <= 8'd0;
            err_r    <= 8'd0;
            sel_r    <= 2'd0;
            locked_r <= 1'b0;
            lost_r   <= 1'b0;
            busy_r   <= 1'b1;
        end else begin
            state_r  <= state_s;
            fill_r   <= fill_s;
            mask_r   <= mask_s;
            good_r   <= good_s;
            err_r    <= err_s;
            sel_r    <= sel_s;
            locked_r <= locked_s;
            lost_r   <= lost_s;
            busy_r   <= (state_s != ST_LOCKED);
        end
    end

    assign sel       = sel_r;
    assign locked    = locked_r;
    assign lock_lost = lost_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_delay_detect8.sv
// tb_delay_detect8
//   Randomized bench for delay_detect8. A behavioural model keeps the
//   qualifying compare cycles in a queue and locks when LOCK_CNT consecutive
//   cycles share a common matching tap. Outputs are compared on every
//   falling edge, and directed checks confirm lock timing and pulse counts.
module tb_delay_detect8;

    localparam int LOCK_CNT = 8;
    localparam int ERR_MAX  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] ref_d;
    logic [7:0] dly_d;
    logic [1:0] sel;
    logic       locked;
    logic       lock_lost;
    logic       busy;

    delay_detect8 #(.WIDTH(8), .LOCK_CNT(LOCK_CNT), .ERR_MAX(ERR_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ref_d     (ref_d),
        .dly_d     (dly_d),
        .sel       (sel),
        .locked    (locked),
        .lock_lost (lock_lost),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Stimulus state
    logic [7:0] bh [1:3];      // external delay line / reference history
    int         cur_delay;
    bit         corrupt;
    int         data_mode;     // 0 random, 1 incrementing, 2 constant 0xA5
    logic [7:0] inc_val;

    // Model state
    int         m_phase;       // 0 fill, 1 search, 2 locked
    int         m_fill;
    int         m_err;
    logic [3:0] m_win [$];     // match vectors of the current qualification window
    logic [1:0] m_sel;
    bit         m_locked;
    bit         m_lost;

    int         cyc;
    int         lock_cyc;
    int         loss_cyc;
    int         lost_pulses;

    function automatic logic [1:0] first_tap(input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[k]) return k[1:0];
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_fill   = 0;
        m_err    = 0;
        m_win.delete();
        m_sel    = 2'd0;
        m_locked = 1'b0;
        m_lost   = 1'b0;
        for (int k = 1; k <= 3; k++) bh[k] = 8'h00;
        inc_val     = 8'h00;
        cyc         = 0;
        lock_cyc    = -1;
        loss_cyc    = -1;
        lost_pulses = 0;
    endtask

    // Predict what the coming rising edge does, from current inputs.
    task automatic model_edge();
        logic [3:0] mv;
        logic [3:0] common;
        mv[0] = (dly_d == ref_d);
        for (int k = 1; k <= 3; k++) mv[k] = (dly_d == bh[k]);
        m_lost = 1'b0;
        if (m_phase == 0) begin
            m_fill++;
            if (m_fill == 3) m_phase = 1;
        end else if (m_phase == 1) begin
            if (en) begin
                m_win.push_back(mv);
                common = 4'b1111;
                foreach (m_win[i]) common = common & m_win[i];
                if (common == 4'b0000) begin
                    m_win.delete();
                end else if (m_win.size() == LOCK_CNT) begin
                    m_sel    = first_tap(common);
                    m_phase  = 2;
                    m_locked = 1'b1;
                    m_err    = 0;
                    m_win.delete();
                end
            end
        end else begin
            if (en) begin
                if (mv[m_sel]) begin
                    m_err = 0;
                end else begin
                    m_err++;
                    if (m_err == ERR_MAX) begin
                        m_phase  = 1;
                        m_locked = 1'b0;
                        m_lost   = 1'b1;
                        m_win.delete();
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs (called at a falling edge), run the edge, compare.
    task automatic step();
        case (data_mode)
            1:       ref_d = inc_val;
            2:       ref_d = 8'hA5;
            default: ref_d = 8'($urandom);
        endcase
        inc_val = inc_val + 8'd1;
        dly_d = (cur_delay == 0) ? ref_d : bh[cur_delay];
        if (corrupt) dly_d = ~dly_d;
        model_edge();
        @(posedge clk);
        cyc++;
        bh[3] = bh[2];
        bh[2] = bh[1];
        bh[1] = ref_d;
        @(negedge clk);
        check_eq("sel", {30'd0, sel}, (m_locked || m_sel != 2'd0) ? {30'd0, m_sel} : 32'd0);
        check_eq("locked", {31'd0, locked}, {31'd0, m_locked});
        check_eq("lock_lost", {31'd0, lock_lost}, {31'd0, m_lost});
        check_eq("busy", {31'd0, busy}, (m_phase != 2) ? 32'd1 : 32'd0);
        if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
        if (lock_lost === 1'b1) begin
            lost_pulses++;
            loss_cyc = cyc;
            lock_cyc = -1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int mode, input int dly);
        rst_n     = 1'b0;
        en        = 1'b1;
        corrupt   = 1'b0;
        data_mode = mode;
        cur_delay = dly;
        ref_d     = 8'h00;
        dly_d     = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_sel", {30'd0, sel}, 32'd0);
        check_eq("rst_locked", {31'd0, locked}, 32'd0);
        check_eq("rst_lost", {31'd0, lock_lost}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
    endtask

    initial begin
        // Delay 2, incrementing data: lock visible after edge 11.
        do_reset(1, 2);
        run(14);
        check_eq("t1_lock_cyc", lock_cyc, 32'd11);
        check_eq("t1_sel", {30'd0, sel}, 32'd2);
        check_eq("t1_busy", {31'd0, busy}, 32'd0);

        // Delay 0 and delay 3 with random data.
        do_reset(0, 0);
        run(14);
        check_eq("t2_lock_cyc", lock_cyc, 32'd11);
        check_eq("t2_sel", {30'd0, sel}, 32'd0);
        do_reset(0, 3);
        run(14);
        check_eq("t3_lock_cyc", lock_cyc, 32'd11);
        check_eq("t3_sel", {30'd0, sel}, 32'd3);

        // Delay 1, short corruption bursts must not lose lock.
        do_reset(0, 1);
        run(14);
        check_eq("t4_sel", {30'd0, sel}, 32'd1);
        corrupt = 1'b1; run(2);
        corrupt = 1'b0; run(1);
        corrupt = 1'b1; run(2);
        corrupt = 1'b0; run(4);
        check_eq("t4_locked", {31'd0, locked}, 32'd1);
        check_eq("t4_no_loss", lost_pulses, 32'd0);

        // Delay switch 1 -> 3: loss after 3 misses, relock 8 cycles later.
        cur_delay = 3;
        run(3);
        check_eq("t5_lost_now", {31'd0, lock_lost}, 32'd1);
        check_eq("t5_unlocked", {31'd0, locked}, 32'd0);
        run(12);
        check_eq("t5_pulses", lost_pulses, 32'd1);
        check_eq("t5_relock_gap", lock_cyc - loss_cyc, 32'd8);
        check_eq("t5_sel", {30'd0, sel}, 32'd3);

        // Constant data: every tap matches, smallest delay wins.
        do_reset(2, 2);
        run(14);
        check_eq("t6_lock_cyc", lock_cyc, 32'd11);
        check_eq("t6_sel", {30'd0, sel}, 32'd0);

        // en dropped for 5 cycles mid-SEARCH delays lock by exactly 5.
        do_reset(0, 1);
        run(6);
        en = 1'b0; run(5);
        en = 1'b1; run(8);
        check_eq("t7_lock_cyc", lock_cyc, 32'd16);
        check_eq("t7_sel", {30'd0, sel}, 32'd1);

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t8_async_sel", {30'd0, sel}, 32'd0);
        check_eq("t8_async_locked", {31'd0, locked}, 32'd0);
        check_eq("t8_async_busy", {31'd0, busy}, 32'd1);
        do_reset(0, 1);
        run(14);
        check_eq("t8_lock_cyc", lock_cyc, 32'd11);
        check_eq("t8_sel", {30'd0, sel}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
